// File: rtl/eight_to_three_encoder.sv
// Sequential 8-to-3 priority encoder: merges multi-hot requests into a pending
// register and serves one code per cycle over a valid/ready handshake.
module eight_to_three_encoder #(
    parameter int HIGH_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] req_in,
    input  logic       req_valid,
    output logic [2:0] code_out,
    output logic       code_valid,
    input  logic       code_ready,
    output logic [7:0] pending,
    output logic [3:0] pend_count,
    output logic       dup_err,
    input  logic       err_clr
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t     state_q, state_d;
    logic [7:0] p_q, p_d;
    logic [2:0] code_q, code_d;
    logic       vld_q, vld_d;
    logic       dup_q, dup_d;
    logic [2:0] sel;
    logic       load;
    logic [7:0] clr_mask;
    logic [7:0] req_m;

    // Selection looks only at registered P; later loop iterations win.
    always_comb begin
        sel = 3'd0;
        if (HIGH_FIRST != 0) begin
            for (int i = 0; i < 8; i++) begin
                if (p_q[i]) sel = 3'(i);
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (p_q[i]) sel = 3'(i);
            end
        end
    end

    always_comb begin
        pend_count = 4'd0;
        for (int i = 0; i < 8; i++) begin
            pend_count = pend_count + {3'b000, p_q[i]};
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        vld_d   = vld_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && (p_q != 8'd0)) begin
                    load    = 1'b1;
                    code_d  = sel;
                    vld_d   = 1'b1;
                    state_d = HOLD;
                end else begin
                    vld_d   = 1'b0;
                end
            end
            HOLD: begin
                if (code_ready) begin
                    if (enable && (p_q != 8'd0)) begin
                        load   = 1'b1;
                        code_d = sel;
                    end else begin
                        code_d  = 3'd0;
                        vld_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                code_d  = 3'd0;
                vld_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // A request for the bit being served this edge re-arms it and is not a duplicate.
    always_comb begin
        clr_mask = load ? (8'd1 << sel) : 8'd0;
        req_m    = req_valid ? req_in : 8'd0;
        p_d      = (p_q & ~clr_mask) | req_m;
        if ((req_m & p_q & ~clr_mask) != 8'd0) dup_d = 1'b1;
        else if (err_clr)                      dup_d = 1'b0;
        else                                   dup_d = dup_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= 8'd0;
            code_q  <= 3'd0;
            vld_q   <= 1'b0;
            dup_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            code_q  <= code_d;
            vld_q   <= vld_d;
            dup_q   <= dup_d;
        end
    end

    assign code_out   = code_q;
    assign code_valid = vld_q;
    assign pending    = p_q;
    assign dup_err    = dup_q;

endmodule

// File: tb/tb_eight_to_three_encoder.sv
// Directed bench for eight_to_three_encoder: both priority orders, a code
// scoreboard fed at stimulus time and drained on each accepted handshake.
module tb_eight_to_three_encoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic       code_ready = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] req_in = 8'd0;
    logic       req_valid = 1'b0;
    logic [7:0] req_in_lo = 8'd0;
    logic       req_valid_lo = 1'b0;

    logic [2:0] code_hi, code_lo;
    logic       vld_hi, vld_lo;
    logic [7:0] pend_hi, pend_lo;
    logic [3:0] cnt_hi, cnt_lo;
    logic       dup_hi, dup_lo;

    int tests = 0;
    int fails = 0;
    logic [2:0] q_hi[$];
    logic [2:0] q_lo[$];

    always #5 clk = ~clk;

    eight_to_three_encoder #(.HIGH_FIRST(1)) dut_hi (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req_in(req_in), .req_valid(req_valid),
        .code_out(code_hi), .code_valid(vld_hi), .code_ready(code_ready),
        .pending(pend_hi), .pend_count(cnt_hi), .dup_err(dup_hi), .err_clr(err_clr)
    );

    eight_to_three_encoder #(.HIGH_FIRST(0)) dut_lo (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req_in(req_in_lo), .req_valid(req_valid_lo),
        .code_out(code_lo), .code_valid(vld_lo), .code_ready(code_ready),
        .pending(pend_lo), .pend_count(cnt_lo), .dup_err(dup_lo), .err_clr(err_clr)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: a handshake seen at the negedge completes on the next posedge.
    always @(negedge clk) begin
        if (vld_hi && code_ready) begin
            if (q_hi.size() == 0) chk("sb_hi_unexpected", 8'(code_hi), 8'hEE);
            else chk("sb_hi_code", 8'(code_hi), 8'(q_hi.pop_front()));
        end
        if (vld_lo && code_ready) begin
            if (q_lo.size() == 0) chk("sb_lo_unexpected", 8'(code_lo), 8'hEE);
            else chk("sb_lo_code", 8'(code_lo), 8'(q_lo.pop_front()));
        end
    end

    initial begin
        // reset state
        tick(); tick();
        chk("rst_code", 8'(code_hi), 8'h00);
        chk("rst_vld", 8'(vld_hi), 8'h00);
        chk("rst_pend", pend_hi, 8'h00);
        chk("rst_cnt", 8'(cnt_hi), 8'h00);
        chk("rst_dup", 8'(dup_hi), 8'h00);
        rst_n = 1'b1;
        tick();

        // A4 pulse, both priority orders
        code_ready = 1'b1;
        req_in = 8'hA4; req_valid = 1'b1;
        req_in_lo = 8'hA4; req_valid_lo = 1'b1;
        q_hi.push_back(3'd7); q_hi.push_back(3'd5); q_hi.push_back(3'd2);
        q_lo.push_back(3'd2); q_lo.push_back(3'd5); q_lo.push_back(3'd7);
        tick();
        req_valid = 1'b0; req_valid_lo = 1'b0;
        chk("a4_pend_k", pend_hi, 8'hA4);
        chk("a4_cnt_k", 8'(cnt_hi), 8'd3);
        chk("a4_vld_k", 8'(vld_hi), 8'h00);
        tick();
        chk("a4_code7", 8'(code_hi), 8'd7);
        chk("a4_vld1", 8'(vld_hi), 8'd1);
        chk("a4_pend24", pend_hi, 8'h24);
        chk("a4_cnt2", 8'(cnt_hi), 8'd2);
        chk("lo_code2", 8'(code_lo), 8'd2);
        chk("lo_pendA0", pend_lo, 8'hA0);
        tick();
        chk("a4_pend04", pend_hi, 8'h04);
        chk("a4_cnt1", 8'(cnt_hi), 8'd1);
        chk("lo_code5", 8'(code_lo), 8'd5);
        tick();
        chk("a4_pend00", pend_hi, 8'h00);
        chk("a4_cnt0", 8'(cnt_hi), 8'd0);
        chk("a4_code2", 8'(code_hi), 8'd2);
        chk("lo_code7", 8'(code_lo), 8'd7);
        tick();
        chk("a4_vld_end", 8'(vld_hi), 8'h00);
        chk("a4_code_idle", 8'(code_hi), 8'h00);
        chk("lo_vld_end", 8'(vld_lo), 8'h00);

        // backpressure with P=81
        code_ready = 1'b0;
        req_in = 8'h81; req_valid = 1'b1;
        q_hi.push_back(3'd7); q_hi.push_back(3'd0);
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("bp_code7", 8'(code_hi), 8'd7);
            chk("bp_vld", 8'(vld_hi), 8'd1);
            chk("bp_pend01", pend_hi, 8'h01);
            tick();
        end
        code_ready = 1'b1;
        tick();
        chk("bp_code0", 8'(code_hi), 8'd0);
        chk("bp_vld0", 8'(vld_hi), 8'd1);
        chk("bp_pend00", pend_hi, 8'h00);
        tick();
        chk("bp_idle", 8'(vld_hi), 8'h00);

        // re-request of the bit served on the same edge
        enable = 1'b0; code_ready = 1'b0;
        req_in = 8'h08; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("rr_pend08", pend_hi, 8'h08);
        chk("rr_vld0", 8'(vld_hi), 8'h00);
        enable = 1'b1; req_valid = 1'b1;
        q_hi.push_back(3'd3); q_hi.push_back(3'd3);
        tick();
        req_valid = 1'b0;
        chk("rr_code3", 8'(code_hi), 8'd3);
        chk("rr_pend_reset", pend_hi, 8'h08);
        chk("rr_nodup", 8'(dup_hi), 8'h00);
        code_ready = 1'b1;
        tick();
        chk("rr_code3_again", 8'(code_hi), 8'd3);
        chk("rr_vld_again", 8'(vld_hi), 8'd1);
        chk("rr_pend00", pend_hi, 8'h00);
        tick();
        chk("rr_idle", 8'(vld_hi), 8'h00);
        chk("rr_nodup2", 8'(dup_hi), 8'h00);

        // duplicate request: sticky flag, set beats clear
        enable = 1'b0;
        req_in = 8'h10; req_valid = 1'b1;
        tick();
        chk("dup_first_clean", 8'(dup_hi), 8'h00);
        tick();
        req_valid = 1'b0;
        chk("dup_set", 8'(dup_hi), 8'd1);
        chk("dup_pend10", pend_hi, 8'h10);
        tick();
        chk("dup_sticky", 8'(dup_hi), 8'd1);
        err_clr = 1'b1; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("dup_set_wins", 8'(dup_hi), 8'd1);
        tick();
        err_clr = 1'b0;
        chk("dup_cleared", 8'(dup_hi), 8'h00);
        q_hi.push_back(3'd4);
        enable = 1'b1;
        tick();
        chk("dup_code4", 8'(code_hi), 8'd4);
        tick();
        chk("dup_idle", 8'(vld_hi), 8'h00);

        // enable gating then eight back-to-back codes
        enable = 1'b0;
        req_in = 8'hFF; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        chk("en_vld0", 8'(vld_hi), 8'h00);
        chk("en_cnt8", 8'(cnt_hi), 8'd8);
        chk("en_pendFF", pend_hi, 8'hFF);
        for (int i = 7; i >= 0; i--) q_hi.push_back(3'(i));
        enable = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            tick();
            chk("b2b_code", 8'(code_hi), 8'(i));
            chk("b2b_vld", 8'(vld_hi), 8'd1);
        end
        tick();
        chk("b2b_idle", 8'(vld_hi), 8'h00);
        chk("b2b_cnt0", 8'(cnt_hi), 8'd0);

        // asynchronous reset mid-HOLD with P=0F
        code_ready = 1'b0;
        req_in = 8'h0F; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        req_in = 8'h08; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("ar_pend0F", pend_hi, 8'h0F);
        chk("ar_hold_code3", 8'(code_hi), 8'd3);
        chk("ar_hold_vld", 8'(vld_hi), 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_vld0", 8'(vld_hi), 8'h00);
        chk("ar_pend0", pend_hi, 8'h00);
        chk("ar_cnt0", 8'(cnt_hi), 8'h00);
        chk("ar_code0", 8'(code_hi), 8'h00);
        tick();
        rst_n = 1'b1;
        code_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ar_quiet_vld", 8'(vld_hi), 8'h00);
            chk("ar_quiet_pend", pend_hi, 8'h00);
        end

        chk("sb_hi_drained", 8'(q_hi.size()), 8'd0);
        chk("sb_lo_drained", 8'(q_lo.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
